var_load_scheduler: RTL and testbench



---
 rtl/var_load_scheduler_pkg.sv | 27 ++
 rtl/var_load_scheduler_if.sv | 30 +++
 rtl/var_load_scheduler_bank_release_tracker.sv | 37 +++
 rtl/var_load_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_var_load_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/var_load_scheduler_pkg.sv
// Shared types for the variance-loader scheduler: FSM states, bank ids and
// the per-run block step.
package pkg_varLoadScheduler;

  typedef enum logic [2:0] {
    S_Idle,
    S_WaitBank,
    S_Start,
    S_WaitDone,
    S_Ack,
    S_Advance,
    S_Drain,
    S_FrameDone
  } STATES_t;

  typedef logic bank_id_t;

  localparam int DEF_CORES           = 32;
  localparam int DEF_WINDOW_BLOCKING = 4;
  localparam int STEP                = DEF_CORES / DEF_WINDOW_BLOCKING;

  // One loader run covers CORES adjacent windows, i.e. this many blocks.
  function automatic int step_blocks(input int cores, input int wb);
    return cores / wb;
  endfunction

endpackage

// File: rtl/var_load_scheduler_if.sv
// Start/ack handshake and window address bus between the scheduler (master)
// and the variance loader (slave).
interface var_load_scheduler_if
  import pkg_varLoadScheduler::*;
#(
  parameter int ROW_BITS   = 9,
  parameter int BLOCK_BITS = 8,
  parameter int WIN_BITS   = 6
) ();

  logic                  vl_ready;
  logic                  vl_done;
  logic                  vl_start;
  logic [ROW_BITS-1:0]   vl_startY;
  logic [BLOCK_BITS-1:0] vl_startBlock;
  logic [WIN_BITS-1:0]   vl_winSize;
  bank_id_t              vl_dblBuf;
  logic                  vl_ack;

  modport master (
    input  vl_ready, vl_done,
    output vl_start, vl_startY, vl_startBlock, vl_winSize, vl_dblBuf, vl_ack
  );

  modport slave (
    output vl_ready, vl_done,
    input  vl_start, vl_startY, vl_startBlock, vl_winSize, vl_dblBuf, vl_ack
  );

endinterface

// File: rtl/var_load_scheduler_bank_release_tracker.sv
// Per-bank mask of cores still holding the bank; a fill arms every core and
// each core's release clears its own bit.
module bank_release_tracker
  import pkg_varLoadScheduler::*;
#(
  parameter int       CORES = 32,
  parameter bank_id_t BANK  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fill_i,
  input  logic [CORES-1:0] rel_valid_i,
  input  logic [CORES-1:0] rel_bank_i,
  output logic             full_o
);

  logic [CORES-1:0] pending_q;
  logic [CORES-1:0] pending_d;
  logic [CORES-1:0] hit;

  // A fill overrides any release aimed at this bank in the same cycle.
  always_comb begin
    hit       = rel_valid_i & (BANK ? rel_bank_i : ~rel_bank_i);
    pending_d = fill_i ? '1 : (pending_q & ~hit);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign full_o = |pending_q;

endmodule

// File: rtl/var_load_scheduler.sv
// Walks the window origin over a frame, runs the variance loader once per
// origin and ping-pongs its double buffer, waiting for cores to free a bank.
module var_load_scheduler
  import pkg_varLoadScheduler::*;
#(
  parameter int CORES           = 32,
  parameter int WINDOW_BLOCKING = 4,
  parameter int ROW_BITS        = 9,
  parameter int BLOCK_BITS      = 8,
  parameter int WIN_BITS        = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_start,
  input  logic [ROW_BITS-1:0]   cfg_rows,
  input  logic [BLOCK_BITS-1:0] cfg_blocks,
  input  logic [WIN_BITS-1:0]   cfg_win,
  var_load_scheduler_if.master  vl,
  input  logic [CORES-1:0]      rel_valid,
  input  logic [CORES-1:0]      rel_bank,
  output logic [1:0]            bank_full,
  output logic                  bank_fill,
  output bank_id_t              bank_fill_id,
  output logic                  frame_done
);

  localparam int RUN_STEP = step_blocks(CORES, WINDOW_BLOCKING);
  localparam int CW       = BLOCK_BITS + WIN_BITS + 1;
  localparam int RW       = ROW_BITS + WIN_BITS + 1;

  STATES_t               state_q, state_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [BLOCK_BITS-1:0] blk_q, blk_d;
  bank_id_t              tgt_q, tgt_d;
  logic [ROW_BITS-1:0]   rows_q, rows_d;
  logic [BLOCK_BITS-1:0] blocks_q, blocks_d;
  logic [WIN_BITS-1:0]   win_q, win_d;

  logic                  start_q;
  logic                  ack_fill_q;
  bank_id_t              fill_id_q;
  logic [ROW_BITS-1:0]   start_y_q;
  logic [BLOCK_BITS-1:0] start_blk_q;
  bank_id_t              dbl_q;

  logic [CW-1:0]         nblk;
  logic [RW-1:0]         nrow;
  logic [1:0]            fill_vec;

  // Rightmost window of the run must still lie inside the image width.
  function automatic logic col_ok(input logic [CW-1:0]         blk,
                                  input logic [BLOCK_BITS-1:0] blocks,
                                  input logic [WIN_BITS-1:0]   win);
    logic [CW-1:0] lhs;
    logic [CW-1:0] rhs;
    lhs = blk * CW'(WINDOW_BLOCKING) + CW'(CORES) + CW'(win) - CW'(1);
    rhs = CW'(blocks) * CW'(WINDOW_BLOCKING);
    return lhs <= rhs;
  endfunction

  function automatic logic row_ok(input logic [RW-1:0]       row,
                                  input logic [ROW_BITS-1:0] rows,
                                  input logic [WIN_BITS-1:0] win);
    return (row + RW'(win)) <= RW'(rows);
  endfunction

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    blk_d    = blk_q;
    tgt_d    = tgt_q;
    rows_d   = rows_q;
    blocks_d = blocks_q;
    win_d    = win_q;
    nblk     = CW'(blk_q) + CW'(RUN_STEP);
    nrow     = RW'(row_q) + RW'(1);

    case (state_q)
      S_Idle: begin
        if (frame_start) begin
          rows_d   = cfg_rows;
          blocks_d = cfg_blocks;
          win_d    = cfg_win;
          row_d    = '0;
          blk_d    = '0;
          tgt_d    = 1'b0;
          if (col_ok('0, cfg_blocks, cfg_win) && row_ok('0, cfg_rows, cfg_win)) begin
            state_d = S_WaitBank;
          end else begin
            state_d = S_FrameDone;
          end
        end
      end
      S_WaitBank: begin
        if (!bank_full[tgt_q] && vl.vl_ready) begin
          state_d = S_Start;
        end
      end
      S_Start:    state_d = S_WaitDone;
      S_WaitDone: begin
        if (vl.vl_done) begin
          state_d = S_Ack;
        end
      end
      S_Ack: begin
        tgt_d   = ~tgt_q;
        state_d = S_Advance;
      end
      S_Advance: begin
        // The current row already passed the row test, so only the column matters here.
        if (col_ok(nblk, blocks_q, win_q)) begin
          blk_d   = nblk[BLOCK_BITS-1:0];
          state_d = S_WaitBank;
        end else begin
          blk_d   = '0;
          row_d   = nrow[ROW_BITS-1:0];
          state_d = row_ok(nrow, rows_q, win_q) ? S_WaitBank : S_Drain;
        end
      end
      S_Drain: begin
        if (bank_full == 2'b00) begin
          state_d = S_FrameDone;
        end
      end
      S_FrameDone: begin
        if (!frame_start) begin
          state_d = S_Idle;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_Idle;
      row_q    <= '0;
      blk_q    <= '0;
      tgt_q    <= 1'b0;
      rows_q   <= '0;
      blocks_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      blk_q    <= blk_d;
      tgt_q    <= tgt_d;
      rows_q   <= rows_d;
      blocks_q <= blocks_d;
      win_q    <= win_d;
    end
  end

  // Loader-facing outputs are registered; the address holds until the next run.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q     <= 1'b0;
      ack_fill_q  <= 1'b0;
      fill_id_q   <= 1'b0;
      start_y_q   <= '0;
      start_blk_q <= '0;
      dbl_q       <= 1'b0;
    end else begin
      start_q    <= (state_q == S_Start);
      ack_fill_q <= (state_q == S_Ack);
      if (state_q == S_Ack) begin
        fill_id_q <= tgt_q;
      end
      if (state_q == S_Start) begin
        start_y_q   <= row_q;
        start_blk_q <= blk_q;
        dbl_q       <= tgt_q;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign fill_vec[gi] = (state_q == S_Ack) && (tgt_q == bank_id_t'(gi));

    bank_release_tracker #(
      .CORES (CORES),
      .BANK  (bank_id_t'(gi))
    ) u_tracker (
      .clk         (clk),
      .resetn      (resetn),
      .fill_i      (fill_vec[gi]),
      .rel_valid_i (rel_valid),
      .rel_bank_i  (rel_bank),
      .full_o      (bank_full[gi])
    );
  end

  assign vl.vl_start      = start_q;
  assign vl.vl_startY     = start_y_q;
  assign vl.vl_startBlock = start_blk_q;
  assign vl.vl_winSize    = win_q;
  assign vl.vl_dblBuf     = dbl_q;
  assign vl.vl_ack        = ack_fill_q;
  assign bank_fill        = ack_fill_q;
  assign bank_fill_id     = fill_id_q;
  assign frame_done       = (state_q == S_FrameDone);

endmodule

// File: tb/tb_var_load_scheduler.sv
// Randomized bench for var_load_scheduler: a loader model, core release
// model and a frame-walk reference queue derived from the validity rules.
module tb_var_load_scheduler;
  import pkg_varLoadScheduler::*;

  localparam int CORES = 8;
  localparam int WB    = 4;
  localparam int RB    = 9;
  localparam int BB    = 8;
  localparam int WBITS = 6;
  localparam int STEP_T = CORES / WB;

  localparam int LD_READY = 0;
  localparam int LD_BUSY  = 1;
  localparam int LD_DONE  = 2;
  localparam int LD_REC   = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             frame_start = 1'b0;
  logic [RB-1:0]    cfg_rows = '0;
  logic [BB-1:0]    cfg_blocks = '0;
  logic [WBITS-1:0] cfg_win = '0;
  logic [CORES-1:0] rel_valid = '0;
  logic [CORES-1:0] rel_bank = '0;
  logic [1:0]       bank_full;
  logic             bank_fill;
  bank_id_t         bank_fill_id;
  logic             frame_done;

  var_load_scheduler_if #(.ROW_BITS(RB), .BLOCK_BITS(BB), .WIN_BITS(WBITS)) vl_if ();

  var_load_scheduler #(
    .CORES(CORES), .WINDOW_BLOCKING(WB), .ROW_BITS(RB), .BLOCK_BITS(BB), .WIN_BITS(WBITS)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start),
    .cfg_rows(cfg_rows), .cfg_blocks(cfg_blocks), .cfg_win(cfg_win),
    .vl(vl_if), .rel_valid(rel_valid), .rel_bank(rel_bank),
    .bank_full(bank_full), .bank_fill(bank_fill), .bank_fill_id(bank_fill_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int blk; int bank; } run_t;

  int n_cmp = 0;
  int n_bad = 0;
  run_t exp_q[$];
  logic [CORES-1:0] pend [2];
  int rel_tmr [2][CORES];
  logic [CORES-1:0] prev_rv, prev_rb;
  int fill_cnt, start_cnt, exp_total, cur_win;
  int ld_state, ld_cnt;
  int last_row, last_blk, first_row, first_blk, first_bank;
  bit mode_fixed, mode_noise, mode_stall, mode_sim;
  bit stall_hold, sim_hold, sim_fire, sim_check, sim_fired;
  int stall_wait;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    pend[0] = '0;
    pend[1] = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < CORES; i++) rel_tmr[b][i] = -1;
    prev_rv = '0; prev_rb = '0;
    fill_cnt = 0; start_cnt = 0;
    ld_state = LD_READY; ld_cnt = 0;
    rel_valid = '0; rel_bank = '0;
    vl_if.vl_ready = 1'b1;
    vl_if.vl_done  = 1'b0;
    sim_fire = 0; sim_check = 0;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({vl_if.vl_start, vl_if.vl_ack, vl_if.vl_startY, vl_if.vl_startBlock,
                vl_if.vl_winSize, vl_if.vl_dblBuf, bank_full, bank_fill, bank_fill_id, frame_done});
  endfunction

  task automatic observe();
    run_t r;
    int b;
    for (int i = 0; i < CORES; i++)
      if (prev_rv[i]) pend[prev_rb[i] ? 1 : 0][i] = 1'b0;
    if (bank_fill === 1'b1) begin
      b = fill_cnt % 2;
      check_eq("fill_id", 32'(bank_fill_id), 32'(b));
      pend[b] = '1;
      fill_cnt++;
      for (int i = 0; i < CORES; i++) begin
        rel_tmr[b][i] = mode_fixed ? 5 : int'($urandom_range(1, 8));
        if (mode_stall && stall_hold && b == 0 && i == 3) rel_tmr[b][i] = -1;
        if (mode_sim && sim_hold && b == 1) rel_tmr[b][i] = -1;
      end
    end
    if (bank_fill === 1'b1 || vl_if.vl_ack === 1'b1)
      check_eq("fill_with_ack", 32'(bank_fill), 32'(vl_if.vl_ack));
    check_eq("bank_full", 32'(bank_full), 32'({|pend[1], |pend[0]}));
    if (sim_check) begin
      check_eq("simul_full", 32'(bank_full), 32'd1);
      sim_check = 0;
      sim_fired = 1;
    end
    if (vl_if.vl_start === 1'b1) begin
      check_eq("start_ld_ready", ld_state, LD_READY);
      if (exp_q.size() == 0) begin
        check_eq("extra_start", start_cnt + 1, exp_total);
      end else begin
        r = exp_q.pop_front();
        check_eq("start_row", 32'(vl_if.vl_startY), r.row);
        check_eq("start_blk", 32'(vl_if.vl_startBlock), r.blk);
        check_eq("start_bank", 32'(vl_if.vl_dblBuf), r.bank);
        check_eq("start_win", 32'(vl_if.vl_winSize), cur_win);
      end
      if (start_cnt == 0) begin
        first_row = int'(vl_if.vl_startY);
        first_blk = int'(vl_if.vl_startBlock);
        first_bank = int'(vl_if.vl_dblBuf);
      end
      last_row = int'(vl_if.vl_startY);
      last_blk = int'(vl_if.vl_startBlock);
      start_cnt++;
      ld_state = LD_BUSY;
      ld_cnt = $urandom_range(1, 5);
    end
    if (vl_if.vl_ack === 1'b1) begin
      check_eq("ack_state", ld_state, LD_DONE);
      ld_state = LD_REC;
      ld_cnt = 2;
    end
  endtask

  task automatic drive();
    logic [CORES-1:0] rv, rb;
    int b;
    rv = '0; rb = '0;
    if (sim_fire) begin
      rv = '1; rb = '1;
      sim_fire = 0; sim_hold = 0; sim_check = 1;
    end else begin
      for (int bb = 0; bb < 2; bb++)
        for (int i = 0; i < CORES; i++)
          if (rel_tmr[bb][i] > 0) begin
            rel_tmr[bb][i]--;
            if (rel_tmr[bb][i] == 0) begin
              if (!rv[i]) begin
                rv[i] = 1'b1; rb[i] = (bb == 1); rel_tmr[bb][i] = -1;
              end else begin
                rel_tmr[bb][i] = 1;
              end
            end
          end
      if (mode_noise)
        for (int i = 0; i < CORES; i++)
          if (!rv[i] && $urandom_range(0, 15) == 0) begin
            b = $urandom_range(0, 1);
            if (!pend[b][i] && rel_tmr[b][i] < 0) begin
              rv[i] = 1'b1; rb[i] = (b == 1);
            end
          end
    end
    rel_valid = rv; rel_bank = rb;
    prev_rv = rv; prev_rb = rb;
    case (ld_state)
      LD_BUSY: begin
        ld_cnt--;
        if (ld_cnt <= 0) begin
          ld_state = LD_DONE;
          if (mode_sim && sim_hold && start_cnt == 3) sim_fire = 1;
        end
      end
      LD_REC: begin
        ld_cnt--;
        if (ld_cnt <= 0) ld_state = LD_READY;
      end
      default: ;
    endcase
    vl_if.vl_ready = (ld_state == LD_READY);
    vl_if.vl_done  = (ld_state == LD_DONE);
    frame_start = mode_noise && (ld_state == LD_BUSY) && ($urandom_range(0, 7) == 0);
  endtask

  task automatic run_frame(input int rows, input int blocks, input int win,
                           input bit stop_for_rst, output int done_lat);
    run_t r;
    bit done_seen;
    bit stopped;
    int idx;
    idx = 0;
    exp_q.delete();
    for (int row = 0; row + win <= rows; row++)
      for (int blk = 0; blk * WB + CORES + win - 1 <= blocks * WB; blk += STEP_T) begin
        r.row = row; r.blk = blk; r.bank = idx % 2;
        exp_q.push_back(r);
        idx++;
      end
    exp_total = idx;
    start_cnt = 0; fill_cnt = 0; cur_win = win;
    done_seen = 0; stopped = 0; done_lat = -1;
    cfg_rows = RB'(rows); cfg_blocks = BB'(blocks); cfg_win = WBITS'(win);
    frame_start = 1'b1;
    for (int c = 0; c < 8000 && !done_seen && !stopped; c++) begin
      @(posedge clk); #1;
      observe();
      if (frame_done === 1'b1) begin
        done_seen = 1;
        done_lat = c + 1;
        check_eq("done_runs_left", exp_q.size(), 0);
        check_eq("done_banks", 32'(bank_full), 0);
        check_eq("start_count", start_cnt, exp_total);
      end
      if (mode_stall && stall_hold && start_cnt >= 2) begin
        stall_wait++;
        if (stall_wait == 60) begin
          check_eq("stall_starts", start_cnt, 2);
          stall_hold = 0;
          rel_tmr[0][3] = 1;
        end
      end
      if (stop_for_rst && start_cnt == 2 && ld_state == LD_BUSY) stopped = 1;
      else drive();
    end
    if (!stop_for_rst) begin
      check_eq("frame_timeout", done_seen, 1);
      @(posedge clk); #1;
      observe();
      check_eq("frame_done_drop", 32'(frame_done), 0);
      drive();
    end else begin
      check_eq("rst_reached", stopped, 1);
    end
  endtask

  initial begin
    int lat;
    mode_fixed = 1; mode_noise = 0; mode_stall = 0; mode_sim = 0;
    stall_hold = 0; sim_hold = 0; sim_fired = 0; stall_wait = 0;
    reset_model();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", all_outputs(), 0);
    resetn = 1'b1;

    // Base frame: 7 rows x 3 block positions.
    run_frame(10, 8, 4, 0, lat);
    check_eq("base_starts", start_cnt, 21);
    check_eq("base_last_row", last_row, 6);
    check_eq("base_last_blk", last_blk, 4);
    $display("base frame: %0d starts, last origin (%0d,%0d)", start_cnt, last_row, last_blk);

    // Core 3 holds bank 0 after its first fill.
    mode_stall = 1; stall_hold = 1; stall_wait = 0;
    run_frame(5, 8, 4, 0, lat);
    check_eq("stall_released", stall_hold, 0);
    mode_stall = 0;
    $display("stall frame: %0d starts", start_cnt);

    // Window taller than the image: nothing to load.
    run_frame(10, 8, 12, 0, lat);
    check_eq("empty_starts", start_cnt, 0);
    check_eq("empty_latency_ok", (lat >= 1 && lat <= 3), 1);
    $display("empty frame: frame_done after %0d cycles", lat);

    // Release of bank 1 coincides with the fill of bank 0.
    mode_sim = 1; sim_hold = 1; sim_fired = 0;
    run_frame(6, 8, 4, 0, lat);
    check_eq("simul_fired", sim_fired, 1);
    mode_sim = 0;
    $display("simultaneous frame: %0d starts", start_cnt);

    // Reset while the loader is busy, then restart.
    run_frame(10, 8, 4, 1, lat);
    resetn = 1'b0; frame_start = 1'b0; rel_valid = '0; rel_bank = '0;
    @(posedge clk); #1;
    check_eq("rst_outputs", all_outputs(), 0);
    resetn = 1'b1;
    reset_model();
    run_frame(4, 8, 4, 0, lat);
    check_eq("restart_row", first_row, 0);
    check_eq("restart_blk", first_blk, 0);
    check_eq("restart_bank", first_bank, 0);
    $display("restart frame: %0d starts", start_cnt);

    // Random frames with random release delays, duplicate releases and stray frame_start.
    mode_fixed = 0; mode_noise = 1;
    for (int k = 0; k < 6; k++) begin
      int rw, bl, wn;
      rw = $urandom_range(4, 10);
      bl = $urandom_range(3, 10);
      wn = $urandom_range(2, 6);
      run_frame(rw, bl, wn, 0, lat);
      $display("random frame %0d: rows=%0d blocks=%0d win=%0d starts=%0d", k, rw, bl, wn, start_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
